// File: rtl/word_burst_pkg.sv
// Shared types and width helpers for the word burst writer.
package word_burst_pkg;

  // Default geometry of the UART->FIFO->DDR path.
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ADDR_W     = 28;
  localparam int DEF_BURST_LEN  = 8;
  localparam int DEF_FIFO_DEPTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Byte stride of one word on the DDR byte-address bus.
  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

  // Width of a field that must hold 0..n inclusive, where n is a power of two.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// First-word-fall-through word buffer: the head is visible on o_data
// combinationally, and the occupancy count is registered.
module word_fifo
  import word_burst_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_push,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_pop,
  output logic [DATA_W-1:0]       o_data,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full,
  output logic                    o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push, do_pop;

  // Full/empty come from the registered count, so a pop in the same cycle
  // never makes room for a push into a full buffer.
  assign o_full  = (count == CNT_W'(DEPTH));
  assign o_empty = (count == '0);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_data  = mem[rd_ptr];
  assign o_count = count;

  // Storage array carries no reset; contents are meaningless after reset.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/word_burst_writer.sv
// Buffers packetizer words and drains them to the DDR native write port as
// fixed-length bursts at incrementing addresses; a flush drains a partial burst.
module word_burst_writer
  import word_burst_pkg::*;
#(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                BURST_LEN  = DEF_BURST_LEN,
  parameter int                FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  input  logic [DATA_W-1:0]            i_data,
  input  logic                         i_flush,
  output logic                         o_cmd_valid,
  input  logic                         i_cmd_ready,
  output logic [ADDR_W-1:0]            o_cmd_addr,
  output logic [$clog2(BURST_LEN):0]   o_cmd_len,
  output logic                         o_wr_valid,
  input  logic                         i_wr_ready,
  output logic [DATA_W-1:0]            o_wr_data,
  output logic                         o_wr_last,
  output logic                         o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]  o_level
);
  localparam int LEN_W = cnt_width(BURST_LEN);
  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam int BPW   = bytes_per_word(DATA_W);

  state_t            state;
  logic [LEN_W-1:0]  len_q, beat_q;
  logic [ADDR_W-1:0] addr_q;
  logic              flush_q, cmd_valid_q, wr_valid_q, wr_last_q, overflow_q;

  logic [CNT_W-1:0]  count;
  logic              fifo_full, fifo_empty, pop;
  logic              burst_rdy, part_rdy;

  assign pop       = wr_valid_q && i_wr_ready && !fifo_empty;
  assign burst_rdy = (count >= CNT_W'(BURST_LEN));
  // A full burst takes precedence; the flush then catches whatever is left.
  assign part_rdy  = flush_q && (count != '0) && !burst_rdy;

  word_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_valid),
    .i_data  (i_data),
    .i_pop   (pop),
    .o_data  (o_wr_data),
    .o_count (count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Sticky drop flag: no backpressure upstream, so a push into full is lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                  overflow_q <= 1'b0;
    else if (i_valid && fifo_full) overflow_q <= 1'b1;
  end

  // Flush latch: a new pulse wins; otherwise IDLE consumes it whenever no
  // full burst is pending (partial burst issued, or nothing to drain).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                            flush_q <= 1'b0;
    else if (i_flush)                        flush_q <= 1'b1;
    else if (state == ST_IDLE && !burst_rdy) flush_q <= 1'b0;
  end

  // Burst sequencer: command issue, beat counting and address advance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      beat_q      <= '0;
      addr_q      <= BASE_ADDR;
      cmd_valid_q <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_last_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (burst_rdy) begin
            state       <= ST_CMD;
            len_q       <= LEN_W'(BURST_LEN);
            cmd_valid_q <= 1'b1;
          end else if (part_rdy) begin
            state       <= ST_CMD;
            len_q       <= LEN_W'(count);
            cmd_valid_q <= 1'b1;
          end
        end
        ST_CMD: begin
          if (i_cmd_ready) begin
            state       <= ST_DATA;
            cmd_valid_q <= 1'b0;
            wr_valid_q  <= 1'b1;
            beat_q      <= '0;
            wr_last_q   <= (len_q == LEN_W'(1));
          end
        end
        ST_DATA: begin
          if (pop) begin
            if (wr_last_q) begin
              state      <= ST_IDLE;
              wr_valid_q <= 1'b0;
              wr_last_q  <= 1'b0;
              addr_q     <= addr_q + ADDR_W'(len_q) * ADDR_W'(BPW);
            end else begin
              beat_q    <= beat_q + 1'b1;
              wr_last_q <= (beat_q + LEN_W'(2) == len_q);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_valid = cmd_valid_q;
  assign o_cmd_addr  = addr_q;
  assign o_cmd_len   = len_q;
  assign o_wr_valid  = wr_valid_q;
  assign o_wr_last   = wr_last_q;
  assign o_overflow  = overflow_q;
  assign o_level     = count;

endmodule

// File: tb/tb_word_burst_writer.sv
// Directed bench for word_burst_writer. A second instance with a 5-bit
// address bus shares all stimulus to exercise address wrap-around.
module tb_word_burst_writer;
  logic        i_clk, i_rst_n;
  logic        i_valid, i_flush, i_cmd_ready, i_wr_ready;
  logic [15:0] i_data;

  logic        o_cmd_valid, o_wr_valid, o_wr_last, o_overflow;
  logic [27:0] o_cmd_addr;
  logic [3:0]  o_cmd_len;
  logic [15:0] o_wr_data;
  logic [5:0]  o_level;

  logic        w_cmd_valid, w_wr_valid, w_wr_last, w_overflow;
  logic [4:0]  w_cmd_addr;
  logic [3:0]  w_cmd_len;
  logic [15:0] w_wr_data;
  logic [5:0]  w_level;

  int checks = 0;
  int failures = 0;

  word_burst_writer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data),
    .i_flush(i_flush), .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready),
    .o_cmd_addr(o_cmd_addr), .o_cmd_len(o_cmd_len), .o_wr_valid(o_wr_valid),
    .i_wr_ready(i_wr_ready), .o_wr_data(o_wr_data), .o_wr_last(o_wr_last),
    .o_overflow(o_overflow), .o_level(o_level)
  );

  word_burst_writer #(.ADDR_W(5), .BASE_ADDR(5'h10)) dut_wrap (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data),
    .i_flush(i_flush), .o_cmd_valid(w_cmd_valid), .i_cmd_ready(i_cmd_ready),
    .o_cmd_addr(w_cmd_addr), .o_cmd_len(w_cmd_len), .o_wr_valid(w_wr_valid),
    .i_wr_ready(i_wr_ready), .o_wr_data(w_wr_data), .o_wr_last(w_wr_last),
    .o_overflow(w_overflow), .o_level(w_level)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_seq(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      i_valid = 1'b1;
      i_data  = 16'(first + i);
      tick();
    end
    i_valid = 1'b0;
  endtask

  initial begin
    int n, b;
    logic [31:0] exp_addr;
    i_rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_flush = 1'b0;
    i_cmd_ready = 1'b0; i_wr_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_cmd_valid", 32'(o_cmd_valid), 0);
    chk("rst_wr_valid",  32'(o_wr_valid), 0);
    chk("rst_wr_last",   32'(o_wr_last), 0);
    chk("rst_overflow",  32'(o_overflow), 0);
    chk("rst_level",     32'(o_level), 0);
    chk("rst_cmd_addr",  32'(o_cmd_addr), 0);
    chk("rst_cmd_len",   32'(o_cmd_len), 0);
    chk("rst_wrap_addr", 32'(w_cmd_addr), 32'h10);
    i_rst_n = 1'b1;
    tick();

    // Full burst with both readies high
    i_cmd_ready = 1'b1; i_wr_ready = 1'b1;
    push_seq(1, 8);
    chk("full_level", 32'(o_level), 8);
    chk("full_cmd_early", 32'(o_cmd_valid), 0);
    tick();
    chk("full_cmd_valid", 32'(o_cmd_valid), 1);
    chk("full_cmd_addr",  32'(o_cmd_addr), 0);
    chk("full_cmd_len",   32'(o_cmd_len), 8);
    chk("wrap_addr_1",    32'(w_cmd_addr), 32'h10);
    tick();
    for (int k = 1; k <= 8; k++) begin
      chk("full_beat_valid", 32'(o_wr_valid), 1);
      chk("full_beat_data",  32'(o_wr_data), 32'(k));
      chk("full_beat_last",  32'(o_wr_last), (k == 8) ? 1 : 0);
      tick();
    end
    chk("full_done_valid", 32'(o_wr_valid), 0);
    chk("full_done_level", 32'(o_level), 0);

    // Backpressure: command stalled 5 cycles, write ready toggling
    i_cmd_ready = 1'b0; i_wr_ready = 1'b0;
    push_seq(16'h11, 8);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_cmd_valid", 32'(o_cmd_valid), 1);
      chk("bp_cmd_addr",  32'(o_cmd_addr), 32'h10);
      chk("bp_cmd_len",   32'(o_cmd_len), 8);
      chk("wrap_addr_2",  32'(w_cmd_addr), 0);
      tick();
    end
    i_cmd_ready = 1'b1;
    tick();
    i_cmd_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      i_wr_ready = c[0];
      if (o_wr_valid && i_wr_ready) begin
        chk("bp_beat_data", 32'(o_wr_data), 32'(16'h11 + n));
        chk("bp_beat_last", 32'(o_wr_last), (n == 7) ? 1 : 0);
        n++;
      end
      tick();
    end
    chk("bp_beat_count", 32'(n), 8);
    chk("bp_done_valid", 32'(o_wr_valid), 0);

    // Partial burst via flush
    i_cmd_ready = 1'b1; i_wr_ready = 1'b1;
    push_seq(16'h21, 3);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    tick();
    chk("fl_cmd_valid", 32'(o_cmd_valid), 1);
    chk("fl_cmd_addr",  32'(o_cmd_addr), 32'h20);
    chk("fl_cmd_len",   32'(o_cmd_len), 3);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("fl_beat_valid", 32'(o_wr_valid), 1);
      chk("fl_beat_data",  32'(o_wr_data), 32'(16'h21 + k));
      chk("fl_beat_last",  32'(o_wr_last), (k == 2) ? 1 : 0);
      tick();
    end
    chk("fl_done_level", 32'(o_level), 0);

    // Flush of an empty buffer: no command, and the latch must not linger
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("fe_no_cmd", 32'(o_cmd_valid), 0);
      tick();
    end
    push_seq(16'h31, 3);
    for (int k = 0; k < 4; k++) begin
      chk("fe_latch_clear", 32'(o_cmd_valid), 0);
      tick();
    end
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    tick();
    chk("fl2_cmd_addr", 32'(o_cmd_addr), 32'h26);
    chk("fl2_cmd_len",  32'(o_cmd_len), 3);
    repeat (5) tick();
    chk("fl2_done_level", 32'(o_level), 0);

    // Overflow: 33 words while the controller refuses commands
    i_cmd_ready = 1'b0; i_wr_ready = 1'b0;
    push_seq(1, 32);
    chk("ov_before", 32'(o_overflow), 0);
    push_seq(33, 1);
    chk("ov_level", 32'(o_level), 32);
    chk("ov_flag",  32'(o_overflow), 1);
    repeat (3) tick();
    chk("ov_sticky", 32'(o_overflow), 1);
    i_cmd_ready = 1'b1; i_wr_ready = 1'b1;
    n = 0; b = 0;
    for (int c = 0; c < 120 && n < 32; c++) begin
      if (o_cmd_valid) begin
        exp_addr = 32'h2C + 32'(b) * 16;
        chk("ov_cmd_addr", 32'(o_cmd_addr), exp_addr);
        chk("ov_cmd_len",  32'(o_cmd_len), 8);
        b++;
      end
      if (o_wr_valid) begin
        chk("ov_beat_data", 32'(o_wr_data), 32'(n + 1));
        chk("ov_beat_last", 32'(o_wr_last), (n % 8 == 7) ? 1 : 0);
        n++;
      end
      tick();
    end
    chk("ov_beats", 32'(n), 32);
    chk("ov_bursts", 32'(b), 4);
    chk("ov_drained", 32'(o_level), 0);
    chk("ov_still", 32'(o_overflow), 1);

    // Reset in the middle of a burst
    push_seq(16'h41, 8);
    tick();
    tick();
    repeat (3) tick();
    chk("mr_beat4", 32'(o_wr_data), 32'h44);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mr_cmd_valid", 32'(o_cmd_valid), 0);
    chk("mr_wr_valid",  32'(o_wr_valid), 0);
    chk("mr_wr_last",   32'(o_wr_last), 0);
    chk("mr_overflow",  32'(o_overflow), 0);
    chk("mr_level",     32'(o_level), 0);
    chk("mr_cmd_addr",  32'(o_cmd_addr), 0);
    #10 i_rst_n = 1'b1;
    tick();
    chk("mr_post_level", 32'(o_level), 0);
    push_seq(16'h51, 8);
    tick();
    chk("mr_next_valid", 32'(o_cmd_valid), 1);
    chk("mr_next_addr",  32'(o_cmd_addr), 0);
    chk("mr_wrap_addr",  32'(w_cmd_addr), 32'h10);
    tick();
    chk("mr_next_beat", 32'(o_wr_data), 32'h51);
    repeat (9) tick();
    chk("mr_next_done", 32'(o_level), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/word_burst_writer.md
# word_burst_writer

Downstream stage of the byte-to-word packetizer on the UART→FIFO→DDR path. Buffers the 16-bit words it produces in an internal FIFO and drains them to the DDR controller's native write port as fixed-length bursts at linearly incrementing addresses. The input has no backpressure, so overflow is flagged rather than stalled. A flush request drains a partial burst.

## Interface
Parameters:
- DATA_W, 16, word width; must match packetizer output.
- ADDR_W, 28, DDR byte-address width.
- BURST_LEN, 8, words per full burst; power of two, 2..FIFO_DEPTH/2.
- FIFO_DEPTH, 32, word buffer depth; power of two.
- BASE_ADDR, 0, byte address of first burst; aligned to BURST_LEN*DATA_W/8.

Ports:
- i_clk, in, 1, single clock for the whole block.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_valid, in, 1, word strobe from packetizer; one cycle per word.
- i_data, in, DATA_W, word, valid with i_valid.
- i_flush, in, 1, one-cycle pulse; latched until served.
- o_cmd_valid, out, 1, write command valid.
- i_cmd_ready, in, 1, controller accepts command.
- o_cmd_addr, out, ADDR_W, burst start byte address.
- o_cmd_len, out, log2(BURST_LEN)+1, beats in this burst (1..BURST_LEN).
- o_wr_valid, out, 1, write data valid.
- i_wr_ready, in, 1, controller accepts beat.
- o_wr_data, out, DATA_W, beat data.
- o_wr_last, out, 1, final beat of burst.
- o_overflow, out, 1, sticky: a word was dropped.
- o_level, out, log2(FIFO_DEPTH)+1, current FIFO occupancy.

## Operation
- Reset (async assert, sync release): FSM=IDLE; pointers, count, beat counter, flush latch, o_overflow = 0; address register = BASE_ADDR; all outputs 0, except o_cmd_addr = BASE_ADDR and o_wr_data = don't-care. Reset mid-burst abandons the burst; words in the FIFO are lost.
- Push: i_valid && !full writes i_data. i_valid while full drops the word and sets o_overflow. Full is judged on the registered count, so a same-cycle pop does not rescue a push into a full FIFO.
- Pop: only in DATA, on o_wr_valid && i_wr_ready. Push and pop in the same cycle leave count unchanged.
- FSM:
  - IDLE → CMD when count ≥ BURST_LEN: len = BURST_LEN.
  - IDLE → CMD when the flush latch is set and 0 < count < BURST_LEN: len = count as sampled; the latch clears on entering CMD.
  - Flush with count = 0: the latch clears and the FSM stays in IDLE.
  - CMD: o_cmd_valid = 1 and o_cmd_addr/o_cmd_len are held stable until i_cmd_ready; then → DATA.
  - DATA: o_wr_valid = 1 (count ≥ len is guaranteed). o_wr_data = FIFO head (first-word fall-through). o_wr_last = 1 when the beat counter = len−1. Beat is accepted on i_wr_ready. Accepting the last beat → IDLE, and address += len*DATA_W/8, modulo 2^ADDR_W (wraps silently).
- A flush arriving during CMD or DATA is latched and served after the current burst.

## Timing
- A word with i_valid at edge E is counted at E; o_level reflects it after E.
- If count reaches BURST_LEN at edge E, the FSM enters CMD at E+1 and o_cmd_valid is high in the cycle after E+1.
- Command acceptance at edge C puts the first beat on o_wr_valid in the cycle after C.
- With i_wr_ready held high, the burst takes len cycles and there are no bubbles between beats.
- There is a minimum one IDLE cycle between bursts.
- All outputs are registered, except o_wr_data, which comes from the FIFO read port.

## Structure
- Package word_burst_pkg: FSM state enum (ST_IDLE, ST_CMD, ST_DATA), BYTES_PER_WORD, derived width constants.
- Sub-module word_fifo: synchronous FWFT FIFO with push/pop/count/full/empty. The FSM, address generation and flush latch stay in the top.

## Test plan
- Full burst: 8 words 0x0001..0x0008 on consecutive cycles, ready tied high → one command at addr 0x0, len 8; beats 0x0001..0x0008; o_wr_last on beat 8; next address 0x10.
- Backpressure: i_cmd_ready low for 5 cycles, i_wr_ready toggling → command fields stable while waiting; data order preserved; no beat duplicated or lost.
- Flush partial: 3 words then i_flush → command len 3, beats in order, o_wr_last on the 3rd beat, next address = previous + 6. Flush with an empty FIFO → no command.
- Overflow: i_cmd_ready held low, 33 words pushed → o_level = 32, o_overflow = 1 and stays 1. After release, 4 bursts drain words 1..32.
- Address wrap: ADDR_W = 5, BASE_ADDR = 0x10 → second burst at 0x00.
- Reset mid-burst: assert i_rst_n low during DATA beat 4 → all outputs 0 immediately; after release, o_level = 0 and the next burst starts at BASE_ADDR.
